// File: rtl/din_debouncer.sv
// Debounces a raw asynchronous input into a clean level with rise/fall strobes; DEBOUNCE_TOGGLE_EN adds toggle_o.
// Latency SYNC_STAGES+CNT_MAX edges from a stable raw change to level_o; no backpressure, strobes are fire-and-forget.
module din_debouncer #(
  parameter int   SYNC_STAGES = 2,
  parameter int   CNT_MAX     = 16,
  parameter logic RESET_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
`ifdef DEBOUNCE_TOGGLE_EN
  ,
  output logic toggle_o
`endif
);

  localparam int            CW       = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam bit            DIRECT   = (CNT_MAX == 1);

  typedef enum logic [1:0] {
    ST_STABLE_LO = 2'd0,
    ST_WAIT_HI   = 2'd1,
    ST_STABLE_HI = 2'd2,
    ST_WAIT_LO   = 2'd3
  } state_t;

  localparam state_t ST_RESET = RESET_LEVEL ? ST_STABLE_HI : ST_STABLE_LO;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_s;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [CW-1:0]          r_cnt;
  logic [CW-1:0]          w_cnt_nxt;
  logic                   r_level;
  logic                   w_level_nxt;
  logic                   r_rise;
  logic                   w_rise_nxt;
  logic                   r_fall;
  logic                   w_fall_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {SYNC_STAGES{RESET_LEVEL}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], din_i};
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RESET;
      r_cnt   <= '0;
      r_level <= RESET_LEVEL;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_level <= w_level_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
    end
  end

  // A single opposite sample in a WAIT state drops the count back to zero.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_level_nxt = r_level;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;
    case (r_state)
      ST_STABLE_LO: begin
        if (w_s) begin
          if (DIRECT) begin
            w_state_nxt = ST_STABLE_HI;
            w_cnt_nxt   = '0;
            w_level_nxt = 1'b1;
            w_rise_nxt  = 1'b1;
          end else begin
            w_state_nxt = ST_WAIT_HI;
            w_cnt_nxt   = CNT_ONE;
          end
        end
      end
      ST_WAIT_HI: begin
        if (!w_s) begin
          w_state_nxt = ST_STABLE_LO;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = ST_STABLE_HI;
          w_cnt_nxt   = '0;
          w_level_nxt = 1'b1;
          w_rise_nxt  = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_ONE;
        end
      end
      ST_STABLE_HI: begin
        if (!w_s) begin
          if (DIRECT) begin
            w_state_nxt = ST_STABLE_LO;
            w_cnt_nxt   = '0;
            w_level_nxt = 1'b0;
            w_fall_nxt  = 1'b1;
          end else begin
            w_state_nxt = ST_WAIT_LO;
            w_cnt_nxt   = CNT_ONE;
          end
        end
      end
      ST_WAIT_LO: begin
        if (w_s) begin
          w_state_nxt = ST_STABLE_HI;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = ST_STABLE_LO;
          w_cnt_nxt   = '0;
          w_level_nxt = 1'b0;
          w_fall_nxt  = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = ST_RESET;
        w_cnt_nxt   = '0;
        w_level_nxt = RESET_LEVEL;
      end
    endcase
  end

  assign level_o = r_level;
  assign rise_o  = r_rise;
  assign fall_o  = r_fall;

`ifdef DEBOUNCE_TOGGLE_EN
  logic r_toggle;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_toggle <= 1'b0;
    end else if (r_rise) begin
      r_toggle <= ~r_toggle;
    end
  end

  assign toggle_o = r_toggle;
`endif

endmodule

// File: tb/tb_din_debouncer.sv
// Directed bench for din_debouncer with CNT_MAX=4, SYNC_STAGES=2, RESET_LEVEL=0, 10 ns clock.
module tb_din_debouncer;

  logic clk;
  logic rst_n;
  logic din_i;
  logic level_o;
  logic rise_o;
  logic fall_o;
`ifdef DEBOUNCE_TOGGLE_EN
  logic toggle_o;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int n_rise   = 0;
  int n_fall   = 0;
  int n_both   = 0;
  int n_alt    = 0;
  int last_strobe = 0;

  din_debouncer #(
    .SYNC_STAGES(2),
    .CNT_MAX    (4),
    .RESET_LEVEL(1'b0)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .din_i   (din_i),
    .level_o (level_o),
    .rise_o  (rise_o),
    .fall_o  (fall_o)
`ifdef DEBOUNCE_TOGGLE_EN
    ,
    .toggle_o(toggle_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (rise_o && fall_o) n_both++;
      if (rise_o) begin
        n_rise++;
        if (last_strobe == 1) n_alt++;
        last_strobe = 1;
      end
      if (fall_o) begin
        n_fall++;
        if (last_strobe == 2) n_alt++;
        last_strobe = 2;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive a new raw value and verify it lands on exactly the sixth edge.
  task automatic qualify(input logic val, input string tag);
    int r0;
    int f0;
    r0 = n_rise;
    f0 = n_fall;
    din_i = val;
    for (int i = 1; i <= 5; i++) begin
      tick(1);
      check({tag, "_hold"}, level_o, !val);
    end
    tick(1);
    check({tag, "_level"}, level_o, val);
    check({tag, "_rise"}, rise_o, val);
    check({tag, "_fall"}, fall_o, !val);
    tick(1);
    check({tag, "_strobe_end"}, {30'd0, rise_o, fall_o}, 32'd0);
    check({tag, "_nrise"}, n_rise - r0, val ? 1 : 0);
    check({tag, "_nfall"}, n_fall - f0, val ? 0 : 1);
  endtask

  initial begin
    int r0;
    int f0;
    logic [4:0] bounce;
`ifdef DEBOUNCE_TOGGLE_EN
    logic exp_tog;
`endif

    rst_n = 1'b0;
    din_i = 1'b0;
    tick(3);
    check("rst_level", level_o, 0);
    check("rst_rise", rise_o, 0);
    check("rst_fall", fall_o, 0);
`ifdef DEBOUNCE_TOGGLE_EN
    check("rst_toggle", toggle_o, 0);
`endif
    rst_n = 1'b1;
    tick(3);
    check("idle_level", level_o, 0);

    qualify(1'b1, "t1_rise");
    tick(4);
    qualify(1'b0, "t3_fall");
    tick(4);

    // Bounce pattern: 1,1,1,0,1,1 then settle at 0.
    r0 = n_rise;
    f0 = n_fall;
    bounce = 5'b0;
    for (int i = 0; i < 6; i++) begin
      din_i = (i == 3) ? 1'b0 : 1'b1;
      tick(1);
      bounce[0] = bounce[0] | level_o;
    end
    din_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      bounce[0] = bounce[0] | level_o;
    end
    check("t2_level_never_high", bounce[0], 0);
    check("t2_level_end", level_o, 0);
    check("t2_no_rise", n_rise - r0, 0);
    check("t2_no_fall", n_fall - f0, 0);

    // Reset mid WAIT_HI, then requalify from scratch.
    r0 = n_rise;
    din_i = 1'b1;
    tick(4);
    #2 rst_n = 1'b0;
    #1;
    check("t4_rst_level", level_o, 0);
    check("t4_rst_rise", rise_o, 0);
    #1 rst_n = 1'b1;
    check("t4_no_rise_from_wait", n_rise - r0, 0);
    for (int i = 1; i <= 5; i++) begin
      tick(1);
      check("t4_requal_hold", level_o, 0);
    end
    tick(1);
    check("t4_requal_level", level_o, 1);
    check("t4_requal_rise", rise_o, 1);
    tick(4);

    // Reset mid WAIT_LO drops level at once with no fall strobe.
    f0 = n_fall;
    din_i = 1'b0;
    tick(4);
    check("t4b_pre_level", level_o, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t4b_rst_level", level_o, 0);
    check("t4b_rst_fall", fall_o, 0);
    #1 rst_n = 1'b1;
    tick(8);
    check("t4b_no_fall", n_fall - f0, 0);
    check("t4b_level", level_o, 0);

    // Back-to-back changes every 10 cycles.
    r0 = n_rise;
    f0 = n_fall;
    last_strobe = 0;
    for (int k = 0; k < 4; k++) begin
      qualify((k % 2) == 0, "t5_seq");
      tick(3);
    end
    check("t5_nrise", n_rise - r0, 2);
    check("t5_nfall", n_fall - f0, 2);

`ifdef DEBOUNCE_TOGGLE_EN
    rst_n = 1'b0;
    din_i = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    check("t6_toggle_init", toggle_o, 0);
    exp_tog = 1'b0;
    for (int p = 0; p < 3; p++) begin
      din_i = 1'b1;
      tick(6);
      check("t6_rise", rise_o, 1);
      check("t6_toggle_before", toggle_o, exp_tog);
      tick(1);
      exp_tog = ~exp_tog;
      check("t6_toggle_after", toggle_o, exp_tog);
      tick(3);
      din_i = 1'b0;
      tick(10);
      check("t6_toggle_hold", toggle_o, exp_tog);
    end
`endif

    check("never_both_strobes", n_both, 0);
    check("strobes_alternate", n_alt, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
